// File: rtl/sdft_frame_scheduler_if.sv
// Scheduler <-> sliding-DFT engine / consumer bundle.
// Carries run control, the engine start/ready handshake, the streamed bin bus,
// the frame-buffer read port and the published frame results and status flags.
interface sdft_frame_scheduler_if #(
  parameter int BIN_W = 7,
  parameter int VAL_W = 24
);
  // run control
  logic             enable;
  logic             clear_err;
  // engine handshake and bin stream
  logic             sdft_start;
  logic             sdft_ready;
  logic [BIN_W-1:0] bin_num;
  logic [VAL_W-1:0] bin_val;
  // frame buffer read port
  logic [BIN_W-1:0] rd_addr;
  logic [VAL_W-1:0] rd_data;
  // frame results and status
  logic             frame_valid;
  logic [BIN_W-1:0] peak_bin;
  logic [VAL_W-1:0] peak_val;
  logic [31:0]      sample_count;
  logic             busy;
  logic             overrun;
  logic             timeout_err;

  // master: the scheduler itself
  modport master (
    input  enable, clear_err, sdft_ready, bin_num, bin_val, rd_addr,
    output sdft_start, rd_data, frame_valid, peak_bin, peak_val,
           sample_count, busy, overrun, timeout_err
  );

  // slave: engine plus downstream consumer
  modport slave (
    output enable, clear_err, sdft_ready, bin_num, bin_val, rd_addr,
    input  sdft_start, rd_data, frame_valid, peak_bin, peak_val,
           sample_count, busy, overrun, timeout_err
  );
endinterface

// File: rtl/sdft_frame_scheduler.sv
// Sliding-DFT frame scheduler: paces the engine at one start per sample tick,
// captures the streamed bin magnitudes into a readable buffer and tracks the
// peak non-DC bin; flags overrun (tick while busy) and engine timeout.
// Ports: clk, rst (async, active high), bus (sdft_frame_scheduler_if.master):
//   enable/clear_err control, sdft_start/sdft_ready/bin_num/bin_val engine side,
//   rd_addr/rd_data buffer read (1-cycle latency), frame_valid/peak_bin/peak_val/
//   sample_count results, busy/overrun/timeout_err status.
module sdft_frame_scheduler #(
  parameter int CLK_DIV = 15625,
  parameter int BINS    = 128,
  parameter int BIN_W   = 7,
  parameter int VAL_W   = 24,
  parameter int TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  sdft_frame_scheduler_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BINS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;
  logic [BIN_W-1:0] prev_bin;
  logic [BIN_W-1:0] run_bin;
  logic [BIN_W-1:0] run_bin_nxt;
  logic [VAL_W-1:0] run_val;
  logic [VAL_W-1:0] run_val_nxt;
  logic [BIN_W:0]   cap_cnt;
  logic             capture;
  logic             take_peak;
  logic             frame_end;
  logic [BIN_W-1:0] peak_bin_q;
  logic [VAL_W-1:0] peak_val_q;
  logic [31:0]      sample_cnt_q;
  logic             overrun_q;
  logic             timeout_q;
  logic [VAL_W-1:0] rd_q;
  logic [VAL_W-1:0] mem [BINS];

  // Sample-rate tick: free-running while enabled, parked at 0 otherwise.
  assign tick = bus.enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!bus.enable || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A new bin is recognised by a change of index; the engine may hold an index
  // for several cycles.
  assign capture   = (state == S_BUSY) && (bus.bin_num != prev_bin);
  // Strict compare keeps the lowest index on ties; bin 0 (DC) never competes.
  assign take_peak = capture && (bus.bin_num != '0) && (bus.bin_val > run_val);
  assign run_bin_nxt = take_peak ? bus.bin_num : run_bin;
  assign run_val_nxt = take_peak ? bus.bin_val : run_val;

  // Ready has priority over a timeout landing on the same cycle.
  assign frame_end = (state == S_BUSY) && bus.sdft_ready;
  assign to_hit    = (state == S_BUSY) && !bus.sdft_ready && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.enable) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!bus.enable)  state_nxt = S_IDLE;
        else if (tick)    state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_BUSY;
      S_BUSY: begin
        if (frame_end)    state_nxt = S_DONE;
        else if (to_hit)  state_nxt = bus.enable ? S_WAIT : S_IDLE;
      end
      // A tick in DONE is serviced as if already waiting.
      S_DONE: begin
        if (!bus.enable)  state_nxt = S_IDLE;
        else if (tick)    state_nxt = S_ISSUE;
        else              state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      prev_bin     <= BIN_LAST;
      run_bin      <= '0;
      run_val      <= '0;
      cap_cnt      <= '0;
      peak_bin_q   <= '0;
      peak_val_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ISSUE) begin
        to_cnt  <= '0;
        run_bin <= '0;
        run_val <= '0;
        cap_cnt <= '0;
      end else if (state == S_BUSY) begin
        to_cnt  <= to_cnt + 1'b1;
        run_bin <= run_bin_nxt;
        run_val <= run_val_nxt;
        if (capture) begin
          prev_bin <= bus.bin_num;
          cap_cnt  <= cap_cnt + 1'b1;
        end
      end
      // Publish on the ready edge, folding in a capture from that same cycle,
      // so results are stable while frame_valid is high.
      if (frame_end) begin
        peak_bin_q   <= run_bin_nxt;
        peak_val_q   <= run_val_nxt;
        sample_cnt_q <= sample_cnt_q + 32'd1;
      end
    end
  end

  // Sticky flags: a set on the same cycle as clear_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == S_BUSY) && tick) overrun_q <= 1'b1;
      else if (bus.clear_err)        overrun_q <= 1'b0;
      if (to_hit)                    timeout_q <= 1'b1;
      else if (bus.clear_err)        timeout_q <= 1'b0;
    end
  end

  // Frame buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (capture) mem[bus.bin_num] <= bus.bin_val;
  end

  // Read-before-write: a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem[bus.rd_addr];
  end

  assign bus.sdft_start   = (state == S_ISSUE);
  assign bus.frame_valid  = (state == S_DONE);
  assign bus.busy         = (state == S_ISSUE) || (state == S_BUSY);
  assign bus.peak_bin     = peak_bin_q;
  assign bus.peak_val     = peak_val_q;
  assign bus.sample_count = sample_cnt_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.rd_data      = rd_q;

endmodule

// File: tb/tb_sdft_frame_scheduler.sv
// Directed bench for sdft_frame_scheduler: instance A (long timeout) runs the
// frame capture, peak, overrun, enable-drop and reset scenarios against a
// behavioural engine; instance B (TIMEOUT=100) is never readied.
module tb_sdft_frame_scheduler;
  localparam int BINS  = 128;
  localparam int BIN_W = 7;
  localparam int VAL_W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdft_frame_scheduler_if #(.BIN_W(BIN_W), .VAL_W(VAL_W)) ia ();
  sdft_frame_scheduler_if #(.BIN_W(BIN_W), .VAL_W(VAL_W)) ib ();

  sdft_frame_scheduler #(.CLK_DIV(16), .BINS(BINS), .BIN_W(BIN_W), .VAL_W(VAL_W), .TIMEOUT(4095))
    dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  sdft_frame_scheduler #(.CLK_DIV(16), .BINS(BINS), .BIN_W(BIN_W), .VAL_W(VAL_W), .TIMEOUT(100))
    dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int eng_lat = 300;
  int n_start_a = 0;
  int n_fv_b = 0;
  logic [VAL_W-1:0] pattern [BINS];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ia.sdft_start) n_start_a++;
    if (ib.frame_valid) n_fv_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bounded wait on a DUT event, sampled on falling edges; t = cycle stamp.
  task automatic wait_for(input string tag, input int which, input int budget, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = ia.sdft_start;
        1:       ok = ia.frame_valid;
        2:       ok = ib.sdft_start;
        default: ok = ib.timeout_err;
      endcase
      if (ok) t = cyc;
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  // Engine model: on a start, stream bins 0..BINS-1 one per BUSY cycle and
  // pulse ready in the eng_lat-th cycle after the start.
  initial begin : engine
    ia.sdft_ready = 1'b0;
    ia.bin_num    = BIN_W'(BINS - 1);
    ia.bin_val    = '0;
    forever begin
      @(negedge clk);
      if (ia.sdft_start) begin
        int lat;
        lat = eng_lat;
        for (int c = 1; c <= lat; c++) begin
          @(negedge clk);
          if (c <= BINS) begin
            ia.bin_num = BIN_W'(c - 1);
            ia.bin_val = pattern[c-1];
          end
          ia.sdft_ready = (c == lat);
        end
        @(negedge clk);
        ia.sdft_ready = 1'b0;
      end
    end
  end

  initial begin : main
    int t0, t1, tf;
    rst = 1'b1;
    ia.enable = 1'b0; ia.clear_err = 1'b0; ia.rd_addr = '0;
    ib.enable = 1'b0; ib.clear_err = 1'b0; ib.rd_addr = '0;
    ib.sdft_ready = 1'b0; ib.bin_num = BIN_W'(BINS - 1); ib.bin_val = '0;
    for (int i = 0; i < BINS; i++) pattern[i] = VAL_W'(i * 10);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_start", 32'(ia.sdft_start), 0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_fv", 32'(ia.frame_valid), 0);
    chk("rst_flags", {30'd0, ia.overrun, ia.timeout_err}, 0);
    chk("rst_count", ia.sample_count, 0);
    chk("rst_peak", {1'b0, ia.peak_bin, ia.peak_val}, 0);
    rst = 1'b0;

    // frame 1: ramp val=bin*10, ready 300 cycles after start
    @(negedge clk);
    ia.enable = 1'b1;
    wait_for("start1", 0, 100, t0);
    wait_for("fv1", 1, 1000, tf);
    chk("fv1_lat", tf - t0, 301);
    chk("peak_bin1", 32'(ia.peak_bin), 127);
    chk("peak_val1", 32'(ia.peak_val), 1270);
    chk("count1", ia.sample_count, 1);
    chk("overrun1", 32'(ia.overrun), 1);
    ia.rd_addr = 7'd5;
    for (int i = 0; i < BINS; i++) pattern[i] = 24'd1;
    pattern[0] = 24'd9999; pattern[3] = 24'd500; pattern[7] = 24'd500;
    @(negedge clk);
    chk("rd5", 32'(ia.rd_data), 50);
    ia.rd_addr = 7'd127;
    @(negedge clk);
    chk("rd127", 32'(ia.rd_data), 1270);

    // frame 2: DC excluded, tie keeps lower index; restart on tick grid
    wait_for("start2", 0, 100, t1);
    chk("start_gap", t1 - t0, 304);
    wait_for("fv2", 1, 1000, tf);
    chk("peak_bin2", 32'(ia.peak_bin), 3);
    chk("peak_val2", 32'(ia.peak_val), 500);
    chk("count2", ia.sample_count, 2);
    ia.clear_err = 1'b1;
    ia.rd_addr = 7'd0;
    eng_lat = 40;
    @(negedge clk);
    ia.clear_err = 1'b0;
    chk("ovr_clear", 32'(ia.overrun), 0);
    chk("rd0", 32'(ia.rd_data), 9999);

    // frame 3: ready after 40 cycles, misses the tick at +15
    wait_for("start3", 0, 100, t0);
    repeat (10) @(negedge clk);
    chk("ovr_pre_tick", 32'(ia.overrun), 0);
    chk("starts3", n_start_a, 3);
    repeat (7) @(negedge clk);
    chk("ovr_post_tick", 32'(ia.overrun), 1);
    wait_for("fv3", 1, 200, tf);
    chk("fv3_lat", tf - t0, 41);

    // frame 4: enable dropped 10 cycles into BUSY
    wait_for("start4", 0, 100, t1);
    chk("start_gap_ovr", t1 - t0, 48);
    repeat (10) @(negedge clk);
    ia.enable = 1'b0;
    wait_for("fv4", 1, 200, tf);
    chk("fv4_lat", tf - t1, 41);
    chk("count4", ia.sample_count, 4);
    ia.clear_err = 1'b1;
    @(negedge clk);
    ia.clear_err = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_start_disabled", n_start_a, 4);
    chk("idle_busy", 32'(ia.busy), 0);
    chk("idle_ovr", 32'(ia.overrun), 0);

    // instance B: engine never ready, TIMEOUT=100
    ib.enable = 1'b1;
    wait_for("b_start1", 2, 100, t0);
    wait_for("b_timeout", 3, 300, t1);
    chk("b_to_cycle", t1 - t0, 101);
    chk("b_busy", 32'(ib.busy), 0);
    chk("b_no_fv", n_fv_b, 0);
    wait_for("b_start2", 2, 100, t1);
    chk("b_restart", t1 - t0, 112);
    chk("b_to_sticky", 32'(ib.timeout_err), 1);
    chk("b_count", ib.sample_count, 0);
    ib.clear_err = 1'b1;
    @(negedge clk);
    ib.clear_err = 1'b0;
    chk("b_to_clear", 32'(ib.timeout_err), 0);
    ib.enable = 1'b0;

    // reset asserted mid-BUSY clears outputs without a clock edge
    ia.enable = 1'b1;
    wait_for("start5", 0, 100, t0);
    repeat (5) @(negedge clk);
    chk("busy_pre_rst", 32'(ia.busy), 1);
    chk("peak_pre_rst", 32'(ia.peak_val), 500);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(ia.busy), 0);
    chk("arst_start", 32'(ia.sdft_start), 0);
    chk("arst_count", ia.sample_count, 0);
    chk("arst_peak", {1'b0, ia.peak_bin, ia.peak_val}, 0);
    chk("arst_flags", {30'd0, ia.overrun, ia.timeout_err}, 0);
    chk("arst_rd", 32'(ia.rd_data), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sdft_frame_scheduler.md
Name: sdft_frame_scheduler

Overview:
- Paces the sliding-DFT engine (calfft_CT-style datapath) at a fixed sample rate: issues one start pulse per sample tick and waits for the engine's ready.
- Captures the 128 bin magnitudes the engine streams out on each update into a readable frame buffer, and tracks the peak non-DC bin.
- Flags overrun and timeout.
- Sits between the ADC sample timing and the downstream power-quality logic.

Parameters:
CLK_DIV, 15625, clk cycles per sample tick (>=2)
BINS, 128, number of frequency bins per frame
BIN_W, 7, bin index width (clog2(BINS))
VAL_W, 24, bin magnitude width
TIMEOUT, 4095, max clk cycles in BUSY before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  run scheduler; low = stop after current frame
clear_err  in  1  one-cycle pulse, clears sticky flags
sdft_start  out  1  one-cycle start pulse to engine
sdft_ready  in  1  engine completion pulse
bin_num  in  BIN_W  engine current bin index
bin_val  in  VAL_W  engine current bin magnitude
rd_addr  in  BIN_W  frame buffer read address
rd_data  out  VAL_W  frame buffer data, 1-cycle read latency
frame_valid  out  1  one-cycle pulse, completed frame published
peak_bin  out  BIN_W  index of largest bin 1..BINS-1 of last frame
peak_val  out  VAL_W  magnitude of that bin
sample_count  out  32  completed frames, wraps at 2^32
busy  out  1  high in ISSUE/BUSY
overrun  out  1  sticky: tick arrived while busy
timeout_err  out  1  sticky: engine exceeded TIMEOUT

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; tick counter 0; prev_bin = BINS-1; frame buffer contents undefined (bench must not check it before the first frame_valid).
- Tick counter: counts 0..CLK_DIV-1 while enable=1, then wraps. tick=1 on the cycle count==CLK_DIV-1. Held at 0 when enable=0.
- IDLE: enable=1 -> WAIT_TICK.
- WAIT_TICK:
  - enable=0 -> IDLE.
  - tick -> ISSUE.
- ISSUE (1 cycle): sdft_start=1; clear timeout counter, running peak, captured count -> BUSY.
- BUSY:
  - Capture: a bin is captured when bin_num != prev_bin. Write bin_val to buf[bin_num]; prev_bin <= bin_num; captured count +1.
  - Peak: if bin_num != 0 and bin_val > running peak, take it. Strict greater-than, so ties keep the lower index.
  - sdft_ready=1 -> DONE. A capture on the same cycle is still taken.
  - Timeout counter reaches TIMEOUT -> set timeout_err, go to WAIT_TICK (IDLE if enable=0). No frame_valid; the buffer is left partially updated.
  - tick during BUSY -> set overrun. The tick is dropped; no second start is issued.
- DONE (1 cycle):
  - frame_valid=1; peak_bin/peak_val <= running values; sample_count +1.
  - Then WAIT_TICK if enable=1, else IDLE.
  - A tick landing in DONE is treated as in WAIT_TICK: go straight to ISSUE next cycle, not overrun.
- enable deassert mid-frame: BUSY completes normally, then IDLE.
- clear_err: clears overrun and timeout_err. If a set condition occurs on the same cycle, set wins.
- Read port: rd_data <= buf[rd_addr] every cycle. A same-cycle write to the same address returns old data.
- sdft_start is never asserted outside ISSUE. Start-to-ready latency is set by the engine; the scheduler does not assume a value.

Test Plan:
- CLK_DIV=16, enable=1, engine model asserts ready 300 cycles after start, streaming bins 0..127 with val=bin*10 -> start pulses exactly 16 cycles apart only when idle; frame_valid 1 cycle after ready; peak_bin=127, peak_val=1270; rd_addr=5 returns 50 next cycle; sample_count=1.
- Bin stream with bin0=9999, bin3=bin7=500, others 1 -> peak_bin=3, peak_val=500 (DC excluded, tie keeps lower index).
- CLK_DIV=16, engine ready delayed 40 cycles -> overrun=1 after first missed tick; one start per frame; clear_err pulse -> overrun=0.
- TIMEOUT=100, engine never asserts ready -> timeout_err=1 at cycle 100 of BUSY, no frame_valid, next tick issues a new start.
- enable dropped 10 cycles into BUSY -> frame completes with frame_valid=1, state IDLE, no further sdft_start; rst asserted mid-BUSY -> all outputs 0 immediately.
